// File: rtl/axis_pkt_rr_arbiter.sv
// Two-input AXI4-Stream packet arbiter with round-robin grant locked per packet
// and a single registered output stage.
//
// state | meaning
// IDLE  | no owner; picks the next winner from the valid ports
// BUSY  | grant locked to one port until its tlast beat is accepted
module axis_pkt_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
    input  logic                  s_axis_tvalid_0,
    input  logic                  s_axis_tlast_0,
    output logic                  s_axis_tready_0,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic                  s_axis_tvalid_1,
    input  logic                  s_axis_tlast_1,
    output logic                  s_axis_tready_1,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  pkt_count_0,
    output logic [CNT_WIDTH-1:0]  pkt_count_1
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [CNT_WIDTH-1:0]  cnt_0_q, cnt_0_d;
    logic [CNT_WIDTH-1:0]  cnt_1_q, cnt_1_d;

    logic out_en;
    logic acc_0;
    logic acc_1;
    logic winner;

    // Readies never look at tvalid, so upstream can't form a combinational loop.
    assign out_en          = !tvalid_q || m_axis_tready;
    assign s_axis_tready_0 = (state_q == ST_BUSY) && grant_q[0] && out_en;
    assign s_axis_tready_1 = (state_q == ST_BUSY) && grant_q[1] && out_en;
    assign acc_0           = s_axis_tvalid_0 && s_axis_tready_0;
    assign acc_1           = s_axis_tvalid_1 && s_axis_tready_1;
    assign winner          = (s_axis_tvalid_0 && s_axis_tvalid_1) ? !last_grant_q
                                                                  : s_axis_tvalid_1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        cnt_0_d      = cnt_0_q;
        cnt_1_d      = cnt_1_q;

        case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid_0 || s_axis_tvalid_1) begin
                    state_d      = ST_BUSY;
                    grant_d      = winner ? 2'b10 : 2'b01;
                    last_grant_d = winner;
                end
            end
            ST_BUSY: begin
                if ((acc_0 && s_axis_tlast_0) || (acc_1 && s_axis_tlast_1)) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase

        if (acc_0) begin
            tdata_d  = s_axis_tdata_0;
            tlast_d  = s_axis_tlast_0;
            tvalid_d = 1'b1;
        end else if (acc_1) begin
            tdata_d  = s_axis_tdata_1;
            tlast_d  = s_axis_tlast_1;
            tvalid_d = 1'b1;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        if (acc_0 && s_axis_tlast_0) begin
            cnt_0_d = cnt_0_q + CNT_WIDTH'(1);
        end
        if (acc_1 && s_axis_tlast_1) begin
            cnt_1_d = cnt_1_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            cnt_0_q      <= '0;
            cnt_1_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            cnt_0_q      <= cnt_0_d;
            cnt_1_q      <= cnt_1_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign grant         = grant_q;
    assign pkt_count_0   = cnt_0_q;
    assign pkt_count_1   = cnt_1_q;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed bench for axis_pkt_rr_arbiter: scoreboard of expected output beats
// plus cycle checks on grant, readies, stalls and packet counters.
module tb_axis_pkt_rr_arbiter;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_tdata_0, s_tdata_1;
    logic          s_tvalid_0, s_tvalid_1;
    logic          s_tlast_0, s_tlast_1;
    logic          s_tready_0, s_tready_1;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic [1:0]    grant;
    logic [CW-1:0] cnt_0, cnt_1;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q[$];
    logic [1:0] grant_log[$];

    axis_pkt_rr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_axis_tdata_0  (s_tdata_0),
        .s_axis_tvalid_0 (s_tvalid_0),
        .s_axis_tlast_0  (s_tlast_0),
        .s_axis_tready_0 (s_tready_0),
        .s_axis_tdata_1  (s_tdata_1),
        .s_axis_tvalid_1 (s_tvalid_1),
        .s_axis_tlast_1  (s_tlast_1),
        .s_axis_tready_1 (s_tready_1),
        .m_axis_tdata    (m_tdata),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tlast    (m_tlast),
        .m_axis_tready   (m_tready),
        .grant           (grant),
        .pkt_count_0     (cnt_0),
        .pkt_count_1     (cnt_1)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic [7:0] d, input logic l);
        if (p == 0) begin
            s_tvalid_0 = v; s_tdata_0 = d; s_tlast_0 = l;
        end else begin
            s_tvalid_1 = v; s_tdata_1 = d; s_tlast_1 = l;
        end
    endtask

    task automatic push_pkt(input int n, input logic [7:0] base, input logic [7:0] step,
                            input logic with_last);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = base + 8'(i) * step;
            exp_q.push_back({with_last && (i == n - 1), d});
        end
    endtask

    // Sends n beats on port p; optional tvalid gap of gap_len cycles before beat gap_at.
    task automatic send_pkt(input int p, input int n, input logic [7:0] base,
                            input logic [7:0] step, input logic with_last,
                            input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            logic       acc;
            int         cyc;
            if (i == gap_at) begin
                drive(p, 1'b0, 8'h00, 1'b0);
                repeat (gap_len) begin
                    @(negedge aclk);
                    check("gap_grant_locked", 32'(grant), (p == 0) ? 32'd1 : 32'd2);
                    check("gap_other_tready", 32'((p == 0) ? s_tready_1 : s_tready_0), 32'd0);
                    sync();
                end
            end
            d = base + 8'(i) * step;
            drive(p, 1'b1, d, with_last && (i == n - 1));
            acc = 1'b0;
            cyc = 0;
            while (!acc) begin
                @(negedge aclk);
                acc = (p == 0) ? s_tready_0 : s_tready_1;
                sync();
                cyc++;
                if (!acc && cyc > 200) begin
                    fails++;
                    $display("FAIL accept_timeout: port %0d beat %0d never accepted", p, i);
                    drive(p, 1'b0, 8'h00, 1'b0);
                    return;
                end
            end
        end
        drive(p, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic pulse_reset();
        aresetn = 1'b0;
        sync();
        aresetn = 1'b1;
    endtask

    // Scoreboard monitor: every output handshake pops one expected beat.
    always @(negedge aclk) begin
        if (aresetn && m_tvalid && m_tready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got data 0x%0h last %0b, expected no beat",
                         m_tdata, m_tlast);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({m_tlast, m_tdata} !== e) begin
                    fails++;
                    $display("FAIL sb_beat: got data 0x%0h last %0b, expected data 0x%0h last %0b",
                             m_tdata, m_tlast, e[7:0], e[8]);
                end
            end
        end
    end

    // Stall stability, grant exclusivity and grant-sequence logging.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat  = '0;
    logic [1:0] prev_grant = 2'b00;
    always @(negedge aclk) begin
        if (aresetn) begin
            if (prev_stall) begin
                check("stall_hold", 32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, prev_beat}));
            end
            if (m_tvalid && !m_tready) begin
                check("stall_treadys", 32'({s_tready_1, s_tready_0}), 32'd0);
            end
            if (grant == 2'b01) check("excl_tready_1", 32'(s_tready_1), 32'd0);
            if (grant == 2'b10) check("excl_tready_0", 32'(s_tready_0), 32'd0);
            if (grant != 2'b00 && grant != prev_grant) grant_log.push_back(grant);
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end else begin
            prev_stall = 1'b0;
        end
        prev_grant = grant;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn    = 1'b0;
        m_tready   = 1'b1;
        s_tdata_0  = '0; s_tvalid_0 = 1'b0; s_tlast_0 = 1'b0;
        s_tdata_1  = '0; s_tvalid_1 = 1'b0; s_tlast_1 = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;

        @(negedge aclk);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_treadys", 32'({s_tready_1, s_tready_0}), 32'd0);
        check("rst_counts", 32'({cnt_1, cnt_0}), 32'd0);
        sync();

        // Single port, first-beat latency
        push_pkt(3, 8'h11, 8'h11, 1'b1);
        fork
            send_pkt(0, 3, 8'h11, 8'h11, 1'b1, -1, 0);
            begin
                @(posedge aclk);
                @(negedge aclk);
                check("lat_edge1_grant", 32'(grant), 32'd1);
                check("lat_edge1_tvalid", 32'(m_tvalid), 32'd0);
                @(posedge aclk);
                @(negedge aclk);
                check("lat_edge2_tvalid", 32'(m_tvalid), 32'd1);
                check("lat_edge2_tdata", 32'(m_tdata), 32'h11);
            end
        join
        @(negedge aclk);
        check("t1_grant_idle", 32'(grant), 32'd0);
        check("t1_count_0", 32'(cnt_0), 32'd1);
        sync();

        // Backpressure mid-packet on port 1
        push_pkt(8, 8'h50, 8'h01, 1'b1);
        fork
            send_pkt(1, 8, 8'h50, 8'h01, 1'b1, -1, 0);
            begin
                repeat (5) @(posedge aclk);
                #1 m_tready = 1'b0;
                repeat (3) @(posedge aclk);
                #1 m_tready = 1'b1;
            end
        join
        repeat (2) sync();
        check("bp_count_1", 32'(cnt_1), 32'd1);

        // Tie and round-robin, two packets per port back to back
        grant_log.delete();
        push_pkt(2, 8'h20, 8'h01, 1'b1);
        push_pkt(2, 8'h40, 8'h01, 1'b1);
        push_pkt(2, 8'h22, 8'h01, 1'b1);
        push_pkt(2, 8'h42, 8'h01, 1'b1);
        fork
            begin
                send_pkt(0, 2, 8'h20, 8'h01, 1'b1, -1, 0);
                send_pkt(0, 2, 8'h22, 8'h01, 1'b1, -1, 0);
            end
            begin
                send_pkt(1, 2, 8'h40, 8'h01, 1'b1, -1, 0);
                send_pkt(1, 2, 8'h42, 8'h01, 1'b1, -1, 0);
            end
        join
        repeat (2) sync();
        check("rr_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check("rr_grant_seq", 32'(grant_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        check("rr_count_0", 32'(cnt_0), 32'd3);
        check("rr_count_1", 32'(cnt_1), 32'd3);

        // Gap in granted packet while the other port waits
        push_pkt(4, 8'h60, 8'h01, 1'b1);
        push_pkt(2, 8'h68, 8'h01, 1'b1);
        fork
            send_pkt(0, 4, 8'h60, 8'h01, 1'b1, 2, 2);
            send_pkt(1, 2, 8'h68, 8'h01, 1'b1, -1, 0);
        join
        repeat (2) sync();
        check("gap_count_0", 32'(cnt_0), 32'd4);
        check("gap_count_1", 32'(cnt_1), 32'd4);

        // Reset mid-packet: second beat held in the output register is dropped
        push_pkt(1, 8'h80, 8'h01, 1'b0);
        send_pkt(0, 2, 8'h80, 8'h01, 1'b0, -1, 0);
        m_tready = 1'b0;
        @(negedge aclk);
        check("pre_rst_held", 32'({m_tvalid, m_tdata}), 32'h181);
        sync();
        pulse_reset();
        @(negedge aclk);
        check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_counts", 32'({cnt_1, cnt_0}), 32'd0);
        m_tready = 1'b1;
        sync();
        grant_log.delete();
        push_pkt(1, 8'h90, 8'h01, 1'b1);
        push_pkt(1, 8'h98, 8'h01, 1'b1);
        fork
            send_pkt(0, 1, 8'h90, 8'h01, 1'b1, -1, 0);
            send_pkt(1, 1, 8'h98, 8'h01, 1'b1, -1, 0);
        join
        repeat (2) sync();
        check("post_rst_first_grant", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'd0, 32'd1);
        check("post_rst_counts", 32'({cnt_1, cnt_0}), 32'h11);

        // Counter wrap with a 4-bit counter: 17 single-beat packets
        pulse_reset();
        for (int k = 0; k < 17; k++) begin
            logic [7:0] d;
            d = 8'hA0 + 8'(k);
            push_pkt(1, d, 8'h01, 1'b1);
            send_pkt(1, 1, d, 8'h01, 1'b1, -1, 0);
        end
        repeat (2) sync();
        check("wrap_count_1", 32'(cnt_1), 32'd1);
        check("wrap_count_0", 32'(cnt_0), 32'd0);

        repeat (4) sync();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
